proc_param: RTL and testbench
=============================

// Module: proc_param
// PURPOSE
//  Parametrised successor of the 9-bit bus-based multicycle processor. Width, register-file depth and
//  instruction set are generalised: N-bit datapath, 2**RB general registers on one shared bus, eight
//  opcodes (mv, mvi, add, sub, and, or, xor, mvnz) and a zero flag. Sits in place of proc, fed by the
//  instruction/data source on DIN, with Run/Done as the per-instruction handshake.
// PARAMETERS
//  N   9  datapath/instruction width; N >= 3 + 2*RB
//  RB  3  register-select field width; register count NR = 2**RB
// PORTS
//  Clock     in   1      single clock, all state updates on rising edge
//  Reset     in   1      synchronous, active-high reset
//  DIN       in   N      instruction word in T0, immediate operand in T1 of mvi
//  Run       in   1      start request, sampled only in T0
//  Done      out  1      high for exactly the final cycle of each instruction
//  BusWires  out  N      shared bus, observable for debug/verification
// BEHAVIOUR
//  - Reset sync, active-high, one clock; single clock domain.
//  - Format: op=IR[N-1:N-3], Rx=IR[2*RB-1:RB], Ry=IR[RB-1:0]; bits between unused, ignored.
//  - Opcodes: 000 mv Rx<-Ry; 001 mvi Rx<-DIN; 010 add; 011 sub (Rx-Ry); 100 and; 101 or; 110 xor;
//    111 mvnz Rx<-Ry only if Z==0.
//  - State T0..T3 (2-bit). Reset wins over all: state->T0; R0..R(NR-1), A, G, IR cleared; Z set to 1.
//    Done=0 and BusWires=0 in reset cycle; no register written in reset cycle.
//  - T0: Done=0, bus=0. Run=1 -> IR<=DIN, go T1; else stay T0. Run ignored in T1..T3.
//  - T1: mv/mvnz: bus=Ry, write Rx (mvnz only if Z==0), Done=1, ->T0.
//        mvi: bus=DIN, Rx<=DIN, Done=1, ->T0.
//        ALU ops: bus=Rx, A<=bus, ->T2.
//  - T2 (ALU): bus=Ry, G<=A op bus, Z<=(result==0), ->T3.
//  - T3 (ALU): bus=G, Rx<=G, Done=1, ->T0.
//  - Latency from Run sample: mv/mvi/mvnz Done in 2nd cycle, ALU ops Done in 4th cycle; next
//    instruction may be presented with Run in the cycle right after Done.
//  - Arithmetic modulo 2**N (two's complement wrap, no carry/overflow out). Z updated only by ALU ops.
//  - Rx==Ry legal: add Rx,Rx doubles; sub Rx,Rx gives 0, Z=1.
//  - Bus: exactly one source per cycle via one-hot selects; no source -> 0. Done, bus combinational
//    from state/IR; all storage registered.
//  - Reset mid-instruction: instruction aborted, partial results discarded (A/G/regs cleared).
// TESTING (N=9, RB=3 unless stated)
//  1. Reset; Run=1, DIN=9'b001_000_000 then DIN=5 -> T1: bus=5, Done=1; R0=5 after edge.
//  2. R0=5,R1=3; Run, DIN=9'b010_000_001 -> A=5 after T1, G=8 after T2, Done in T3, R0=8, Z=0.
//  3. R0=2,R1=3 sub R0,R1 -> R0=9'h1FF, Z=0; then sub R2,R2 -> R2=0, Z=1.
//  4. Z=1: mvnz R3,R0 -> Done=1, R3 unchanged; after add giving nonzero -> mvnz copies R0 to R3.
//  5. Reset asserted in T2 of add -> next cycle T0, Done=0, R0=0, A=G=0, Z=1; Run held in T1..T3 no effect.
//  6. N=16, RB=4: mvi R15,16'hFFFF; mvi R14,1; add R15,R14 -> R15=0, Z=1; xor/and/or spot-checked.

Source files
------------

// File: rtl/proc_param.sv
// Parametrised multicycle bus processor: N-bit datapath, 2**RB registers on one shared bus,
// eight opcodes, zero flag, Run/Done per-instruction handshake.
module proc_param #(
   parameter int N  = 9,
   parameter int RB = 3
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic [N-1:0] DIN,
   input  logic         Run,
   output logic         Done,
   output logic [N-1:0] BusWires
);
   localparam int NR = 2**RB;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_MVNZ = 3'b111;

   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

   state_t                 state, state_nx;
   logic [NR-1:0][N-1:0]   r;
   logic [N-1:0]           ir, a, g, alu;
   logic                   z;
   logic [2:0]             op;
   logic [RB-1:0]          rx, ry;
   logic [NR-1:0]          rout, rin;
   logic                   gout, dinout, ain, gin, irin;

   assign op = ir[N-1:N-3];
   assign rx = ir[2*RB-1:RB];
   assign ry = ir[RB-1:0];

   // Control decode; reset forces every select and write enable low so the
   // reset cycle shows an idle bus and no register write.
   always_comb begin
      state_nx = state;
      Done     = 1'b0;
      rout     = '0;
      rin      = '0;
      gout     = 1'b0;
      dinout   = 1'b0;
      ain      = 1'b0;
      gin      = 1'b0;
      irin     = 1'b0;
      if (!Reset) begin
         case (state)
            T0: begin
               if (Run) begin
                  irin     = 1'b1;
                  state_nx = T1;
               end
            end
            T1: begin
               case (op)
                  OP_MV: begin
                     rout[ry] = 1'b1;
                     rin[rx]  = 1'b1;
                     Done     = 1'b1;
                     state_nx = T0;
                  end
                  OP_MVNZ: begin
                     rout[ry] = 1'b1;
                     rin[rx]  = ~z;
                     Done     = 1'b1;
                     state_nx = T0;
                  end
                  OP_MVI: begin
                     dinout   = 1'b1;
                     rin[rx]  = 1'b1;
                     Done     = 1'b1;
                     state_nx = T0;
                  end
                  default: begin
                     rout[rx] = 1'b1;
                     ain      = 1'b1;
                     state_nx = T2;
                  end
               endcase
            end
            T2: begin
               rout[ry] = 1'b1;
               gin      = 1'b1;
               state_nx = T3;
            end
            default: begin
               gout     = 1'b1;
               rin[rx]  = 1'b1;
               Done     = 1'b1;
               state_nx = T0;
            end
         endcase
      end
   end

   // One-hot selects make the OR-mux equivalent to a plain multiplexer.
   always_comb begin
      BusWires = '0;
      for (int i = 0; i < NR; i++)
         if (rout[i]) BusWires = BusWires | r[i];
      if (gout)   BusWires = BusWires | g;
      if (dinout) BusWires = BusWires | DIN;
   end

   always_comb begin
      case (op)
         OP_ADD:  alu = a + BusWires;
         OP_SUB:  alu = a - BusWires;
         OP_AND:  alu = a & BusWires;
         OP_OR:   alu = a | BusWires;
         OP_XOR:  alu = a ^ BusWires;
         default: alu = '0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= T0;
         r     <= '0;
         a     <= '0;
         g     <= '0;
         ir    <= '0;
         z     <= 1'b1;
      end else begin
         state <= state_nx;
         if (irin) ir <= DIN;
         if (ain)  a  <= BusWires;
         if (gin) begin
            g <= alu;
            z <= (alu == '0);
         end
         for (int i = 0; i < NR; i++)
            if (rin[i]) r[i] <= BusWires;
      end
   end
endmodule

// File: tb/tb_proc_param.sv
// Bench for proc_param: N=9/RB=3 and N=16/RB=4 instances checked cycle by cycle on the bus
// and Done against an architectural register/flag model.
module tb_proc_param;
   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  din9, bus9;
   logic        run9, done9;
   logic [15:0] din16, bus16;
   logic        run16, done16;

   always #5 clk = ~clk;

   proc_param #(.N(9), .RB(3)) u9 (
      .Clock(clk), .Reset(rst), .DIN(din9), .Run(run9), .Done(done9), .BusWires(bus9));
   proc_param #(.N(16), .RB(4)) u16 (
      .Clock(clk), .Reset(rst), .DIN(din16), .Run(run16), .Done(done16), .BusWires(bus16));

   int checks = 0;
   int errors = 0;

   // architectural state: [0] = 9-bit core, [1] = 16-bit core
   logic [15:0] mr [2][16];
   bit          mz [2];

   function automatic logic [15:0] mask(input bit w);
      return w ? 16'hFFFF : 16'h01FF;
   endfunction

   function automatic logic [15:0] obus(input bit w);
      return w ? bus16 : {7'd0, bus9};
   endfunction

   function automatic logic odone(input bit w);
      return w ? done16 : done9;
   endfunction

   task automatic drive(input bit w, input logic r, input logic [15:0] d);
      if (w) begin run16 = r; din16 = d; end
      else   begin run9  = r; din9  = d[8:0]; end
   endtask

   task automatic model_reset();
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 16; i++) mr[w][i] = '0;
         mz[w] = 1'b1;
      end
   endtask

   // Issue one instruction and check bus/Done in every cycle; lb = bus in the Done cycle.
   task automatic exec(input bit w, input logic [2:0] op, input int rx, input int ry,
                       input logic [15:0] imm, output logic [15:0] lb);
      logic [15:0] instr, res, eb, b, m;
      bit          alu_op;
      m      = mask(w);
      instr  = w ? {op, 5'($urandom), 4'(rx), 4'(ry)} : {7'd0, op, 3'(rx), 3'(ry)};
      alu_op = (op >= 3'd2) && (op <= 3'd6);
      @(negedge clk);
      checks++;
      if (odone(w) !== 1'b0 || obus(w) !== 16'd0) begin
         errors++;
         $display("FAIL t0_idle w=%0d: done=%b bus=%h, want done=0 bus=0", w, odone(w), obus(w));
      end
      drive(w, 1'b1, instr);
      @(negedge clk);
      if (op == 3'd1)  drive(w, 1'b0, imm & m);
      else if (alu_op) drive(w, 1'($urandom), 16'($urandom));
      else             drive(w, 1'b0, 16'($urandom));
      #1;
      eb = (op == 3'd1) ? (imm & m) : (alu_op ? mr[w][rx] : mr[w][ry]);
      b  = obus(w);
      checks++;
      if (b !== eb || odone(w) !== !alu_op) begin
         errors++;
         $display("FAIL t1 w=%0d op=%0d rx=%0d ry=%0d: bus=%h done=%b, want bus=%h done=%b",
                  w, op, rx, ry, b, odone(w), eb, !alu_op);
      end
      if (!alu_op) begin
         if (op == 3'd0) mr[w][rx] = mr[w][ry];
         else if (op == 3'd1) mr[w][rx] = imm & m;
         else if (!mz[w]) mr[w][rx] = mr[w][ry];
         lb = b;
      end else begin
         @(negedge clk);
         drive(w, 1'($urandom), 16'($urandom));
         #1;
         checks++;
         if (obus(w) !== mr[w][ry] || odone(w) !== 1'b0) begin
            errors++;
            $display("FAIL t2 w=%0d op=%0d: bus=%h done=%b, want bus=%h done=0",
                     w, op, obus(w), odone(w), mr[w][ry]);
         end
         case (op)
            3'd2:    res = mr[w][rx] + mr[w][ry];
            3'd3:    res = mr[w][rx] - mr[w][ry];
            3'd4:    res = mr[w][rx] & mr[w][ry];
            3'd5:    res = mr[w][rx] | mr[w][ry];
            default: res = mr[w][rx] ^ mr[w][ry];
         endcase
         res = res & m;
         @(negedge clk);
         drive(w, 1'b0, 16'($urandom));
         #1;
         checks++;
         if (obus(w) !== res || odone(w) !== 1'b1) begin
            errors++;
            $display("FAIL t3 w=%0d op=%0d: bus=%h done=%b, want bus=%h done=1",
                     w, op, obus(w), odone(w), res);
         end
         mr[w][rx] = res;
         mz[w]     = (res == 16'd0);
         lb        = obus(w);
      end
   endtask

   task automatic test_reset();
      logic [15:0] lb;
      rst = 1'b1;
      drive(0, 1'b1, 16'h0040);
      drive(1, 1'b1, 16'h2000);
      repeat (2) begin
         @(negedge clk);
         #1;
         checks++;
         if (done9 !== 1'b0 || bus9 !== 9'd0 || done16 !== 1'b0 || bus16 !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: done9=%b bus9=%h done16=%b bus16=%h, want all 0",
                     done9, bus9, done16, bus16);
         end
      end
      drive(0, 1'b0, 16'd0);
      drive(1, 1'b0, 16'd0);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++)  exec(0, 3'd0, i, i, 16'd0, lb);
      for (int i = 0; i < 16; i++) exec(1, 3'd0, i, i, 16'd0, lb);
   endtask

   task automatic test_mvi();
      logic [15:0] lb;
      exec(0, 3'd1, 0, 0, 16'd5, lb);
      checks++;
      if (lb !== 16'd5) begin errors++; $display("FAIL mvi_bus: got %h want 005", lb); end
      exec(0, 3'd0, 1, 0, 16'd0, lb);
      checks++;
      if (lb !== 16'd5) begin errors++; $display("FAIL mvi_r0: got %h want 005", lb); end
   endtask

   task automatic test_add();
      logic [15:0] lb;
      exec(0, 3'd1, 1, 0, 16'd3, lb);
      exec(0, 3'd2, 0, 1, 16'd0, lb);
      checks++;
      if (lb !== 16'd8) begin errors++; $display("FAIL add_result: got %h want 008", lb); end
      exec(0, 3'd7, 2, 0, 16'd0, lb);   // Z=0 -> copy
      exec(0, 3'd0, 3, 2, 16'd0, lb);
      checks++;
      if (lb !== 16'd8) begin errors++; $display("FAIL add_z0_mvnz: got %h want 008", lb); end
      exec(0, 3'd2, 1, 1, 16'd0, lb);
      checks++;
      if (lb !== 16'd6) begin errors++; $display("FAIL add_double: got %h want 006", lb); end
   endtask

   task automatic test_sub_mvnz();
      logic [15:0] lb;
      exec(0, 3'd1, 0, 0, 16'd2, lb);
      exec(0, 3'd1, 1, 0, 16'd3, lb);
      exec(0, 3'd1, 3, 0, 16'h055, lb);
      exec(0, 3'd3, 0, 1, 16'd0, lb);
      checks++;
      if (lb !== 16'h1FF) begin errors++; $display("FAIL sub_wrap: got %h want 1ff", lb); end
      exec(0, 3'd3, 2, 2, 16'd0, lb);
      checks++;
      if (lb !== 16'd0) begin errors++; $display("FAIL sub_self: got %h want 000", lb); end
      exec(0, 3'd7, 3, 0, 16'd0, lb);   // Z=1 -> no write
      exec(0, 3'd0, 4, 3, 16'd0, lb);
      checks++;
      if (lb !== 16'h055) begin errors++; $display("FAIL mvnz_z1_hold: got %h want 055", lb); end
      exec(0, 3'd1, 6, 0, 16'd1, lb);
      exec(0, 3'd2, 6, 6, 16'd0, lb);
      exec(0, 3'd7, 3, 0, 16'd0, lb);
      exec(0, 3'd0, 4, 3, 16'd0, lb);
      checks++;
      if (lb !== 16'h1FF) begin errors++; $display("FAIL mvnz_z0_copy: got %h want 1ff", lb); end
   endtask

   task automatic test_mid_reset();
      logic [15:0] lb;
      exec(0, 3'd1, 0, 0, 16'h0AA, lb);
      exec(0, 3'd1, 1, 0, 16'h011, lb);
      @(negedge clk);
      drive(0, 1'b1, {7'd0, 3'b010, 3'd0, 3'd1});
      @(negedge clk);                   // T1
      drive(0, 1'b1, 16'd0);
      @(negedge clk);                   // T2
      #1;
      checks++;
      if (bus9 !== 9'h011) begin errors++; $display("FAIL midrst_t2: bus=%h want 011", bus9); end
      rst = 1'b1;
      #1;
      checks++;
      if (bus9 !== 9'd0 || done9 !== 1'b0) begin
         errors++;
         $display("FAIL midrst_cycle: bus=%h done=%b want 000/0", bus9, done9);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1'b0, 16'd0);
      #1;
      checks++;
      if (bus9 !== 9'd0 || done9 !== 1'b0) begin
         errors++;
         $display("FAIL midrst_t0: bus=%h done=%b want 000/0", bus9, done9);
      end
      model_reset();
      exec(0, 3'd0, 2, 0, 16'd0, lb);
      checks++;
      if (lb !== 16'd0) begin errors++; $display("FAIL midrst_r0: got %h want 000", lb); end
      exec(0, 3'd1, 0, 0, 16'd7, lb);
      exec(0, 3'd7, 1, 0, 16'd0, lb);   // Z restored to 1 -> hold
      exec(0, 3'd0, 2, 1, 16'd0, lb);
      checks++;
      if (lb !== 16'd0) begin errors++; $display("FAIL midrst_z1: got %h want 000", lb); end
   endtask

   task automatic test_wide();
      logic [15:0] lb;
      exec(1, 3'd1, 15, 0, 16'hFFFF, lb);
      exec(1, 3'd1, 14, 0, 16'h0001, lb);
      exec(1, 3'd1, 13, 0, 16'h1234, lb);
      exec(1, 3'd2, 15, 14, 16'd0, lb);
      checks++;
      if (lb !== 16'd0) begin errors++; $display("FAIL wide_add_wrap: got %h want 0000", lb); end
      exec(1, 3'd7, 13, 14, 16'd0, lb);
      exec(1, 3'd0, 12, 13, 16'd0, lb);
      checks++;
      if (lb !== 16'h1234) begin errors++; $display("FAIL wide_z1: got %h want 1234", lb); end
      exec(1, 3'd1, 1, 0, 16'hF0F0, lb);
      exec(1, 3'd1, 2, 0, 16'h0FF0, lb);
      exec(1, 3'd6, 1, 2, 16'd0, lb);
      checks++;
      if (lb !== 16'hFF00) begin errors++; $display("FAIL wide_xor: got %h want ff00", lb); end
      exec(1, 3'd4, 1, 2, 16'd0, lb);
      checks++;
      if (lb !== 16'h0F00) begin errors++; $display("FAIL wide_and: got %h want 0f00", lb); end
      exec(1, 3'd5, 1, 13, 16'd0, lb);
      checks++;
      if (lb !== 16'h1F34) begin errors++; $display("FAIL wide_or: got %h want 1f34", lb); end
   endtask

   task automatic test_random();
      logic [15:0] lb;
      bit          w;
      for (int k = 0; k < 300; k++) begin
         w = 1'($urandom);
         exec(w, 3'($urandom), int'($urandom_range(w ? 15 : 7)), int'($urandom_range(w ? 15 : 7)),
              16'($urandom), lb);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 1'b0, 16'd0);
      drive(1, 1'b0, 16'd0);
      test_reset();
      test_mvi();
      test_add();
      test_sub_mvnz();
      test_mid_reset();
      test_wide();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
